sha1_msg_padder: RTL and testbench

- Producer side of the SHA-1 core block interface.
- Accepts a byte-aligned message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: 0x80, zero fill, 64-bit bit length.
- Presents 512-bit blocks to the SHA-1 core through its start/msg/next/done handshake.
- Sits between the message source (DMA/ECDSA controller) and the SHA-1 core.

---
 rtl/sha1_pkg.sv | 19 +
 rtl/sha1_pad_word.sv | 32 +++
 rtl/sha1_msg_padder.sv | 189 ++++++++++++++++++
 tb/tb_sha1_msg_padder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder and its word builder.
package sha1_pkg;

    localparam int unsigned SHA1_BLK_W       = 512;
    localparam int unsigned SHA1_WORD_W      = 32;
    localparam int unsigned SHA1_LEN_FIELD_W = 64;

    localparam logic [7:0]  PAD_BYTE  = 8'h80;
    localparam int unsigned PAD_LIMIT = 55;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StPad,
        StPresent,
        StWaitDone
    } sha1_state_e;

endpackage

// File: rtl/sha1_pad_word.sv
// Combinational builder for one 32-bit block word: message bytes, the 0x80 marker,
// zero fill, or one half of the 64-bit length field.
module sha1_pad_word
    import sha1_pkg::*;
(
    input  logic [3:0]                    word_idx_i,
    input  logic [SHA1_WORD_W-1:0]        data_i,
    input  logic [2:0]                    nvalid_i,
    input  logic                          pad_en_i,
    input  logic [1:0]                    pad_pos_i,
    input  logic                          len_en_i,
    input  logic [SHA1_LEN_FIELD_W-1:0]   length_i,
    output logic [SHA1_WORD_W-1:0]        word_o
);

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nvalid_i) begin
                word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
            end else if (pad_en_i && (pad_pos_i == 2'(b))) begin
                word_o[31-8*b -: 8] = PAD_BYTE;
            end
        end
        if (len_en_i && (word_idx_i == 4'd14)) begin
            word_o = length_i[63:32];
        end else if (len_en_i && (word_idx_i == 4'd15)) begin
            word_o = length_i[31:0];
        end
    end

endmodule

// File: rtl/sha1_msg_padder.sv
// Streams a byte-aligned message into padded 512-bit SHA-1 blocks for the core.
// Define SHA1_PAD_LEN_CHECK_EN to reject non-byte-multiple lengths with a sticky err.
module sha1_msg_padder
    import sha1_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic [LEN_W-1:0]              msg_len,
    input  logic [SHA1_WORD_W-1:0]        in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          start,
    output logic [SHA1_BLK_W-1:0]         msg,
    output logic                          blk_valid,
    output logic [SHA1_LEN_FIELD_W-1:0]   length,
    input  logic                          next,
    input  logic                          done,
    output logic                          busy,
    output logic                          err
);

    sha1_state_e       state_q, state_d;
    logic [15:0][31:0] words_q, words_d;
    logic [3:0]        idx_q, idx_d;
    logic [57:0]       blk_idx_q, blk_idx_d;
    logic [63:0]       nbytes_q, nbytes_d;
    logic [63:0]       total_q, total_d;
    logic [63:0]       length_q, length_d;
    logic              in_ready_q, in_ready_d;
    logic              start_q, start_d;
    logic              blk_valid_q, blk_valid_d;
    logic              busy_q, busy_d;

    logic [63:0] len64, go_nbytes, base, rem_w;
    logic [2:0]  nvalid;
    logic        pad_en, last_blk, more_bytes, go_ok;
    logic [31:0] pad_word;

    always_comb begin
        len64 = '0;
        len64[LEN_W-1:0] = msg_len;
    end

    assign go_nbytes  = len64 >> 3;
    // Byte offset of the word slot being written, counted from the message start.
    assign base       = {blk_idx_q, idx_q, 2'b00};
    assign rem_w      = nbytes_q - base;
    assign pad_en     = (nbytes_q >= base) && (rem_w < 64'd4);
    assign nvalid     = (state_q != StFill) ? 3'd0 :
                        (rem_w >= 64'd4)    ? 3'd4 : {1'b0, rem_w[1:0]};
    assign last_blk   = (({6'b0, blk_idx_q} + 64'd1) == total_q);
    assign more_bytes = nbytes_q > {blk_idx_q + 58'd1, 6'b000000};

    sha1_pad_word u_pad_word (
        .word_idx_i (idx_q),
        .data_i     (in_data),
        .nvalid_i   (nvalid),
        .pad_en_i   (pad_en),
        .pad_pos_i  (nbytes_q[1:0]),
        .len_en_i   (last_blk),
        .length_i   (length_q),
        .word_o     (pad_word)
    );

`ifdef SHA1_PAD_LEN_CHECK_EN
    logic err_q, err_d;
    assign go_ok = go && (msg_len[2:0] == 3'd0);
    always_comb begin
        err_d = err_q;
        if ((state_q == StIdle) && go && (msg_len[2:0] != 3'd0)) begin
            err_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err = err_q;
`else
    assign go_ok = go;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        idx_d     = idx_q;
        blk_idx_d = blk_idx_q;
        nbytes_d  = nbytes_q;
        total_d   = total_q;
        length_d  = length_q;
        busy_d    = busy_q;
        unique case (state_q)
            StIdle: begin
                if (go_ok) begin
                    nbytes_d  = go_nbytes;
                    length_d  = len64;
                    total_d   = (go_nbytes >> 6) + 64'd1 +
                                {63'b0, (go_nbytes[5:0] > 6'(PAD_LIMIT))};
                    idx_d     = '0;
                    blk_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = (go_nbytes != 64'd0) ? StFill : StPad;
                end
            end
            StFill: begin
                if (in_valid) begin
                    words_d[4'd15 - idx_q] = pad_word;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = StPresent;
                    end else if (rem_w <= 64'd4) begin
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                words_d[4'd15 - idx_q] = pad_word;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (next) begin
                    blk_idx_d = blk_idx_q + 58'd1;
                    idx_d     = '0;
                    if (!last_blk) begin
                        state_d = more_bytes ? StFill : StPad;
                    end else if (done) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                if (done) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StFill);
        blk_valid_d = (state_d == StPresent);
        start_d     = (state_d == StPresent) && (state_q != StPresent) && (blk_idx_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            words_q     <= '0;
            idx_q       <= '0;
            blk_idx_q   <= '0;
            nbytes_q    <= '0;
            total_q     <= '0;
            length_q    <= '0;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            blk_idx_q   <= blk_idx_d;
            nbytes_q    <= nbytes_d;
            total_q     <= total_d;
            length_q    <= length_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            blk_valid_q <= blk_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign msg       = words_q;
    assign blk_valid = blk_valid_q;
    assign length    = length_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Randomized scoreboard bench: a byte-level padding model predicts every block, a
// monitor compares each presented block while a core model drives next/done.
module tb_sha1_msg_padder;

    logic         clk = 1'b0;
    logic         reset, go, in_valid, next, done;
    logic [63:0]  msg_len;
    logic [31:0]  in_data;
    logic         in_ready, start, blk_valid, busy, err;
    logic [511:0] msg;
    logic [63:0]  length;

    always #5 clk = ~clk;

    sha1_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .msg_len   (msg_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .msg       (msg),
        .blk_valid (blk_valid),
        .length    (length),
        .next      (next),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic [63:0]  len;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg_bytes[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         blocks_left = 0;
    int         core_delay = 0;
    bit         core_same_done = 0;
    bit         in_ready_seen = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pads the message as a flat byte string, then slices it into 64-byte blocks.
    function automatic int model_push(input int nbytes);
        logic [7:0]  p[$];
        logic [63:0] nbits;
        exp_t        e;
        int          nb;
        p = msg_bytes;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        nbits = 64'(nbytes) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(nbits[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int k = 0; k < 64; k++) e.data[511-8*k -: 8] = p[64*b + k];
            e.first = (b == 0);
            e.len   = nbits;
            exp_q.push_back(e);
        end
        return nb;
    endfunction

    initial begin : monitor
        logic         prev_valid;
        logic [511:0] held;
        exp_t         e;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (in_ready) in_ready_seen = 1;
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (blk_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_block: got %h expected no block", msg);
                    end else begin
                        e = exp_q.pop_front();
                        check("block_data", msg, e.data);
                        check("start_first", start, e.first);
                        check("length", length, e.len);
                    end
                    held = msg;
                end else begin
                    check("start_quiet", start, 0);
                    if (blk_valid) check("msg_stable", msg, held);
                end
                prev_valid = blk_valid;
            end
        end
    end

    initial begin : core
        bit last;
        next = 1'b0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (blk_valid && !reset) begin
                repeat (core_delay) @(negedge clk);
                @(posedge clk); #1;
                next = 1'b1;
                last = (blocks_left == 1);
                if (last && core_same_done) done = 1'b1;
                @(posedge clk); #1;
                next = 1'b0;
                if (last && !done) begin
                    done = 1'b1;
                    @(posedge clk); #1;
                end
                done = 1'b0;
                blocks_left--;
            end
        end
    end

    task automatic feed_words(input int nbytes, input bit stall, input bit zero_tail);
        int          nwords, idx, guard;
        logic [31:0] w;
        bit          acc;
        nwords = (nbytes + 3) / 4;
        idx = 0;
        guard = 0;
        while ((idx < nwords) && (guard < 4000)) begin
            for (int j = 0; j < 4; j++) begin
                if (4*idx + j < nbytes) w[31-8*j -: 8] = msg_bytes[4*idx + j];
                else w[31-8*j -: 8] = zero_tail ? 8'h00 : 8'($urandom);
            end
            in_data  = w;
            in_valid = stall ? guard[0] : 1'b1;
            @(negedge clk);
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 4000) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d words expected %0d", idx, nwords);
        end
    endtask

    task automatic run_msg(input int nbytes, input bit stall, input int delay,
                           input bit same_done, input bit fixed);
        int t;
        if (!fixed) begin
            msg_bytes.delete();
            for (int i = 0; i < nbytes; i++) msg_bytes.push_back(8'($urandom));
        end
        core_delay     = delay;
        core_same_done = same_done;
        blocks_left    = model_push(nbytes);
        in_ready_seen  = 0;
        @(posedge clk); #1;
        go = 1'b1;
        msg_len = 64'(nbytes) * 64'd8;
        @(posedge clk); #1;
        go = 1'b0;
        feed_words(nbytes, stall, fixed);
        t = 0;
        while (busy && (t < 3000)) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("busy_drop", busy, 0);
        check("in_ready_idle", in_ready, 0);
        check("blocks_drained", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        go = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        msg_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_msg", msg, 0);
        check("reset_ctl", {in_ready, start, blk_valid, busy, err, length}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        msg_bytes = {8'h61, 8'h62, 8'h63};
        run_msg(3, 0, 0, 0, 1);

        run_msg(0, 0, 2, 0, 0);
        check("no_in_ready_len0", in_ready_seen, 0);

        run_msg(55, 0, 1, 1, 0);
        run_msg(56, 0, 0, 0, 0);
        run_msg(119, 0, 40, 0, 0);
        run_msg(64, 1, 3, 0, 0);

        // Abandon a message mid-fill with reset; nothing of it may surface later.
        blocks_left = 0;
        msg_bytes.delete();
        @(posedge clk); #1;
        go = 1'b1;
        msg_len = 64'd256;
        @(posedge clk); #1;
        go = 1'b0;
        in_valid = 1'b1;
        in_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset_msg", msg, 0);
        check("midreset_ctl", {in_ready, start, blk_valid, busy, err, length}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        msg_bytes = {8'h61, 8'h62, 8'h63};
        run_msg(3, 0, 0, 0, 1);

        for (int r = 0; r < 8; r++) begin
            run_msg(int'($urandom_range(0, 200)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0);
        end

`ifdef SHA1_PAD_LEN_CHECK_EN
        @(posedge clk); #1;
        go = 1'b1;
        msg_len = 64'd23;
        @(posedge clk); #1;
        go = 1'b0;
        @(negedge clk);
        check("len_err_set", err, 1);
        check("len_err_idle", {busy, in_ready}, 0);
        repeat (3) @(negedge clk);
        check("len_err_sticky", err, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("len_err_clear", err, 0);
`else
        check("err_tied", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
